// File: rtl/udma_cfg_arbiter.sv
// uDMA config-bus arbiter: round-robin sharing of the peripheral config ports.
// Optional access-abort timer enabled with `define UDMA_CFG_ARB_TIMEOUT_EN.
module udma_cfg_arbiter #(
    parameter int N_MASTERS      = 2,
    parameter int N_PERIPHS      = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [N_MASTERS-1:0]           mst_req_i,
    input  logic [N_MASTERS-1:0][5:0]      mst_sel_i,
    input  logic [N_MASTERS-1:0][4:0]      mst_addr_i,
    input  logic [N_MASTERS-1:0][31:0]     mst_wdata_i,
    input  logic [N_MASTERS-1:0]           mst_rwn_i,
    output logic [N_MASTERS-1:0]           mst_gnt_o,
    output logic [N_MASTERS-1:0]           mst_rvalid_o,
    output logic [31:0]                    mst_rdata_o,
    output logic                           mst_err_o,
    output logic [31:0]                    periph_data_o,
    output logic [4:0]                     periph_addr_o,
    output logic                           periph_rwn_o,
    output logic [N_PERIPHS-1:0]           periph_valid_o,
    input  logic [N_PERIPHS-1:0][31:0]     periph_data_i,
    input  logic [N_PERIPHS-1:0]           periph_ready_i
);

    localparam int IW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   last_q, last_d;
    logic [IW-1:0]   win_q, win_d;
    logic [5:0]      sel_q, sel_d;
    logic [4:0]      addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic            rwn_q, rwn_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            err_q, err_d;

    logic [IW-1:0]   arb_idx;
    logic            arb_any;
    logic [N_PERIPHS-1:0] sel_hot;
    logic            sel_ok;
    logic            sel_rdy;
    logic [31:0]     sel_data;
    logic            timeout;

    // Requesters above the last winner first, then wrap around to 0..last.
    always_comb begin
        arb_idx = '0;
        arb_any = 1'b0;
        for (int j = 0; j < N_MASTERS; j++) begin
            if (!arb_any && mst_req_i[j] && (IW'(j) > last_q)) begin
                arb_any = 1'b1;
                arb_idx = IW'(j);
            end
        end
        for (int j = 0; j < N_MASTERS; j++) begin
            if (!arb_any && mst_req_i[j] && (IW'(j) <= last_q)) begin
                arb_any = 1'b1;
                arb_idx = IW'(j);
            end
        end
    end

    // An out-of-range sel decodes to no hot bit at all.
    always_comb begin
        sel_hot  = '0;
        sel_data = '0;
        for (int p = 0; p < N_PERIPHS; p++) begin
            if (sel_q == 6'(p)) begin
                sel_hot[p] = 1'b1;
                sel_data   = periph_data_i[p];
            end
        end
        sel_ok  = |sel_hot;
        sel_rdy = |(sel_hot & periph_ready_i);
    end

`ifdef UDMA_CFG_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = '0;
        if (state_q == ACCESS) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign timeout = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d        = state_q;
        last_d         = last_q;
        win_d          = win_q;
        sel_d          = sel_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        rwn_d          = rwn_q;
        rdata_d        = rdata_q;
        err_d          = err_q;
        mst_gnt_o      = '0;
        mst_rvalid_o   = '0;
        periph_valid_o = '0;
        unique case (state_q)
            IDLE: begin
                if (arb_any && !rst_i) begin
                    mst_gnt_o[arb_idx] = 1'b1;
                    win_d   = arb_idx;
                    last_d  = arb_idx;
                    sel_d   = mst_sel_i[arb_idx];
                    addr_d  = mst_addr_i[arb_idx];
                    wdata_d = mst_wdata_i[arb_idx];
                    rwn_d   = mst_rwn_i[arb_idx];
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                periph_valid_o = sel_hot;
                if (!sel_ok) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else if (sel_rdy) begin
                    rdata_d = rwn_q ? sel_data : 32'h0;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (timeout) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (!rst_i) begin
                    mst_rvalid_o[win_q] = 1'b1;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            last_q  <= IW'(N_MASTERS - 1);
            win_q   <= '0;
            sel_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rwn_q   <= 1'b1;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            win_q   <= win_d;
            sel_q   <= sel_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rwn_q   <= rwn_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign periph_addr_o = addr_q;
    assign periph_data_o = wdata_q;
    assign periph_rwn_o  = rwn_q;
    assign mst_rdata_o   = rdata_q;
    assign mst_err_o     = err_q;

endmodule

// File: tb/tb_udma_cfg_arbiter.sv
// Directed bench for udma_cfg_arbiter with a response scoreboard.
// Timeout cases run when UDMA_CFG_ARB_TIMEOUT_EN is defined.
module tb_udma_cfg_arbiter;

    localparam int NM = 2;
    localparam int NP = 8;

    typedef struct {
        int          m;
        logic [31:0] d;
        logic        e;
    } resp_t;

    logic                 clk;
    logic                 rst_i;
    logic [NM-1:0]        mst_req_i;
    logic [NM-1:0][5:0]   mst_sel_i;
    logic [NM-1:0][4:0]   mst_addr_i;
    logic [NM-1:0][31:0]  mst_wdata_i;
    logic [NM-1:0]        mst_rwn_i;
    logic [NM-1:0]        mst_gnt_o;
    logic [NM-1:0]        mst_rvalid_o;
    logic [31:0]          mst_rdata_o;
    logic                 mst_err_o;
    logic [31:0]          periph_data_o;
    logic [4:0]           periph_addr_o;
    logic                 periph_rwn_o;
    logic [NP-1:0]        periph_valid_o;
    logic [NP-1:0][31:0]  periph_data_i;
    logic [NP-1:0]        periph_ready_i;

    int          tests = 0;
    int          fails = 0;
    resp_t       sb[$];
    int          gnt_log[$];
    int          lat[NP];
    logic [31:0] pd[NP];
    logic [31:0] wd[NM];
    logic [4:0]  ad[NM];
    logic        rw[NM];
    logic        tie = 1'b0;
    int          vcnt = 0;
    int          vcyc = 0;
    int          owner = 0;
    resp_t       mon_e;

    udma_cfg_arbiter #(
        .N_MASTERS      (NM),
        .N_PERIPHS      (NP),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .mst_req_i      (mst_req_i),
        .mst_sel_i      (mst_sel_i),
        .mst_addr_i     (mst_addr_i),
        .mst_wdata_i    (mst_wdata_i),
        .mst_rwn_i      (mst_rwn_i),
        .mst_gnt_o      (mst_gnt_o),
        .mst_rvalid_o   (mst_rvalid_o),
        .mst_rdata_o    (mst_rdata_o),
        .mst_err_o      (mst_err_o),
        .periph_data_o  (periph_data_o),
        .periph_addr_o  (periph_addr_o),
        .periph_rwn_o   (periph_rwn_o),
        .periph_valid_o (periph_valid_o),
        .periph_data_i  (periph_data_i),
        .periph_ready_i (periph_ready_i)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Peripheral model: ready after lat[p] cycles of held valid, -1 = never.
    initial begin
        forever begin
            @(negedge clk);
            if (tie) begin
                periph_ready_i = '1;
            end else begin
                for (int p = 0; p < NP; p++) begin
                    periph_ready_i[p] = periph_valid_o[p] &&
                                        (lat[p] >= 0) && (vcnt == lat[p]);
                end
            end
            vcnt = (|periph_valid_o) ? vcnt + 1 : 0;
        end
    end

    always @(negedge clk) begin
        if (|periph_valid_o) begin
            chk("valid_onehot", 32'($onehot(periph_valid_o)), 32'd1);
        end
        if (|mst_rvalid_o) begin
            chk("rvalid_onehot", 32'($onehot(mst_rvalid_o)), 32'd1);
            if (sb.size() == 0) begin
                chk("rvalid_unexpected", 32'(mst_rvalid_o), 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("rv_master", mst_rvalid_o[1] ? 32'd1 : 32'd0,
                    32'(mon_e.m));
                chk("rv_rdata", mst_rdata_o, mon_e.d);
                chk("rv_err", 32'(mst_err_o), 32'(mon_e.e));
            end
        end
    end

    task automatic push(input int m, input logic [31:0] d, input logic e);
        resp_t r;
        r.m = m;
        r.d = d;
        r.e = e;
        sb.push_back(r);
    endtask

    task automatic set_m(input int m, input logic [5:0] s,
                         input logic [4:0] a, input logic [31:0] w,
                         input logic r);
        mst_sel_i[m]   = s;
        mst_addr_i[m]  = a;
        mst_wdata_i[m] = w;
        mst_rwn_i[m]   = r;
        ad[m] = a;
        wd[m] = w;
        rw[m] = r;
    endtask

    task automatic do_reset();
        rst_i     = 1'b1;
        mst_req_i = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_gnt", 32'(mst_gnt_o), 32'd0);
        chk("rst_rvalid", 32'(mst_rvalid_o), 32'd0);
        chk("rst_rdata", mst_rdata_o, 32'd0);
        chk("rst_err", 32'(mst_err_o), 32'd0);
        chk("rst_valid", 32'(periph_valid_o), 32'd0);
        chk("rst_pdata", periph_data_o, 32'd0);
        chk("rst_paddr", 32'(periph_addr_o), 32'd0);
        chk("rst_prwn", 32'(periph_rwn_o), 32'd1);
        rst_i = 1'b0;
        gnt_log.delete();
    endtask

    // Each master requests until it has been granted r0/r1 times.
    task automatic serve(input int r0, input int r1, input int maxc);
        int rem[NM];
        logic [NM-1:0] g;
        rem[0] = r0;
        rem[1] = r1;
        vcyc = 0;
        mst_req_i = {rem[1] > 0, rem[0] > 0};
        for (int c = 0; c < maxc; c++) begin
            #1;
            g = mst_gnt_o;
            for (int m = 0; m < NM; m++) begin
                if (g[m]) begin
                    gnt_log.push_back(m);
                    owner = m;
                end
            end
            if (|periph_valid_o) begin
                vcyc++;
                chk("pdata", periph_data_o, wd[owner]);
                chk("paddr", 32'(periph_addr_o), 32'(ad[owner]));
                chk("prwn", 32'(periph_rwn_o), 32'(rw[owner]));
            end
            @(negedge clk);
            for (int m = 0; m < NM; m++) begin
                if (g[m]) rem[m]--;
            end
            mst_req_i = {rem[1] > 0, rem[0] > 0};
            if (rem[0] == 0 && rem[1] == 0 && sb.size() == 0) break;
        end
        mst_req_i = '0;
        chk("serve_grants_left", 32'(rem[0] + rem[1]), 32'd0);
        chk("serve_sb_left", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        rst_i          = 1'b1;
        mst_req_i      = '0;
        mst_sel_i      = '0;
        mst_addr_i     = '0;
        mst_wdata_i    = '0;
        mst_rwn_i      = '0;
        periph_ready_i = '0;
        for (int p = 0; p < NP; p++) begin
            lat[p] = 0;
            pd[p]  = 32'h5000_0000 + 32'(p);
        end
        pd[2] = 32'hCAFE_0001;
        for (int p = 0; p < NP; p++) periph_data_i[p] = pd[p];
        for (int m = 0; m < NM; m++) set_m(m, 6'd0, 5'd0, 32'd0, 1'b1);

        // Single read with one wait cycle
        do_reset();
        lat[2] = 1;
        set_m(0, 6'd2, 5'd5, 32'h0, 1'b1);
        push(0, 32'hCAFE_0001, 1'b0);
        mst_req_i = 2'b01;
        #1;
        chk("t1_gnt_c0", 32'(mst_gnt_o), 32'h1);
        @(negedge clk);
        mst_req_i = '0;
        chk("t1_valid_c1", 32'(periph_valid_o), 32'h04);
        chk("t1_addr_c1", 32'(periph_addr_o), 32'd5);
        chk("t1_rwn_c1", 32'(periph_rwn_o), 32'd1);
        chk("t1_rvalid_c1", 32'(mst_rvalid_o), 32'd0);
        @(negedge clk);
        chk("t1_valid_c2", 32'(periph_valid_o), 32'h04);
        @(negedge clk);
        chk("t1_valid_c3", 32'(periph_valid_o), 32'h00);
        chk("t1_rvalid_c3", 32'(mst_rvalid_o), 32'h1);
        chk("t1_rdata_c3", mst_rdata_o, 32'hCAFE_0001);
        chk("t1_err_c3", 32'(mst_err_o), 32'd0);
        @(negedge clk);
        chk("t1_rvalid_c4", 32'(mst_rvalid_o), 32'd0);
        chk("t1_rdata_hold", mst_rdata_o, 32'hCAFE_0001);

        // Two masters streaming writes with ready tied high
        do_reset();
        tie = 1'b1;
        set_m(0, 6'd1, 5'd3, 32'hA0A0_0000, 1'b0);
        set_m(1, 6'd1, 5'd4, 32'hB1B1_1111, 1'b0);
        for (int k = 0; k < 4; k++) push(k % 2, 32'd0, 1'b0);
        serve(2, 2, 40);
        chk("t2_ngnt", 32'(gnt_log.size()), 32'd4);
        for (int k = 0; k < 4 && k < gnt_log.size(); k++) begin
            chk("t2_order", 32'(gnt_log[k]), 32'(k % 2));
        end
        tie = 1'b0;

        // Out-of-range peripheral index
        gnt_log.delete();
        set_m(1, 6'd9, 5'd2, 32'h1234_5678, 1'b0);
        push(1, 32'd0, 1'b1);
        serve(0, 1, 20);
        chk("t3_no_valid", 32'(vcyc), 32'd0);
        chk("t3_gnt", 32'(gnt_log.size()), 32'd1);

        // Reset while waiting on ready, then pointer back to master 0
        lat[3] = -1;
        set_m(0, 6'd3, 5'd7, 32'h0, 1'b1);
        mst_req_i = 2'b01;
        #1;
        chk("t4_gnt", 32'(mst_gnt_o), 32'h1);
        @(negedge clk);
        mst_req_i = '0;
        chk("t4_valid_c1", 32'(periph_valid_o), 32'h08);
        @(negedge clk);
        chk("t4_valid_c2", 32'(periph_valid_o), 32'h08);
        rst_i = 1'b1;
        @(negedge clk);
        chk("t4_valid_drop", 32'(periph_valid_o), 32'h00);
        rst_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t4_idle_valid", 32'(periph_valid_o), 32'h00);
        end
        gnt_log.delete();
        set_m(0, 6'd1, 5'd2, 32'h0, 1'b1);
        set_m(1, 6'd1, 5'd6, 32'h0, 1'b1);
        push(0, pd[1], 1'b0);
        push(1, pd[1], 1'b0);
        serve(1, 1, 30);
        chk("t4_ngnt", 32'(gnt_log.size()), 32'd2);
        if (gnt_log.size() > 0) chk("t4_first", 32'(gnt_log[0]), 32'd0);

`ifdef UDMA_CFG_ARB_TIMEOUT_EN
        // Peripheral never answers: abort after 4 valid cycles
        lat[4] = -1;
        set_m(0, 6'd4, 5'd1, 32'h0, 1'b1);
        push(0, 32'd0, 1'b1);
        serve(1, 0, 30);
        chk("t5_vcyc", 32'(vcyc), 32'd4);
        // Ready in the last allowed cycle still completes normally
        lat[5] = 3;
        set_m(0, 6'd5, 5'd9, 32'h0, 1'b1);
        push(0, pd[5], 1'b0);
        serve(1, 0, 30);
        chk("t6_vcyc", 32'(vcyc), 32'd4);
`else
        // Without the timer a slow peripheral is simply waited on
        lat[5] = 10;
        set_m(0, 6'd5, 5'd9, 32'h0, 1'b1);
        push(0, pd[5], 1'b0);
        serve(1, 0, 40);
        chk("t5_vcyc", 32'(vcyc), 32'd11);
`endif

        repeat (3) @(negedge clk);
        chk("end_sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/udma_cfg_arbiter.md
Name: udma_cfg_arbiter

Overview:
- Shares the uDMA peripheral configuration bus between N_MASTERS requesters, e.g. the APB bridge and an autonomous channel re-configurator.
- Arbitration is round-robin. One access is in flight at a time.
- The block drives the per-peripheral valid strobes, waits for the addressed peripheral's ready, then returns read data to the winning requester.
- It sits between the requesters and the peripheral config ports.

Parameters:
- N_MASTERS, 2, number of requesters (>=2)
- N_PERIPHS, 8, number of peripheral config ports (<=64)
- TIMEOUT_CYCLES, 255, access-abort threshold; only used with UDMA_CFG_ARB_TIMEOUT_EN

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- mst_req_i  in  [N_MASTERS]  access request, held until granted
- mst_sel_i  in  [N_MASTERS][5:0]  target peripheral index
- mst_addr_i  in  [N_MASTERS][4:0]  register word address
- mst_wdata_i  in  [N_MASTERS][31:0]  write data
- mst_rwn_i  in  [N_MASTERS]  1=read, 0=write
- mst_gnt_o  out  [N_MASTERS]  request accepted (one-hot, one cycle)
- mst_rvalid_o  out  [N_MASTERS]  access complete (one-hot, one cycle)
- mst_rdata_o  out  32  read data, valid with mst_rvalid_o
- mst_err_o  out  1  access error, valid with mst_rvalid_o
- periph_data_o  out  32  write data to peripherals
- periph_addr_o  out  5  register address to peripherals
- periph_rwn_o  out  1  1=read
- periph_valid_o  out  [N_PERIPHS]  one-hot access strobe
- periph_data_i  in  [N_PERIPHS][31:0]  peripheral read data
- periph_ready_i  in  [N_PERIPHS]  peripheral access done

Behaviour:
- Clocking: single clock clk_i. Reset rst_i is synchronous and active-high; this is fixed.
- Reset values:
  - State IDLE; all *_o = 0.
  - periph_rwn_o = 1.
  - Round-robin last-grant pointer = N_MASTERS-1, so master 0 has highest priority first.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If any mst_req_i is set, the winner is the first requester at or after (last+1) mod N_MASTERS.
  - mst_gnt_o[winner] is combinational, asserted the same cycle.
  - On that clock edge, latch the winner's sel/addr/wdata/rwn and the winner index into registers; last := winner; go to ACCESS.
  - No request: stay in IDLE.
- ACCESS:
  - periph_addr_o, periph_data_o and periph_rwn_o come from the latched registers.
  - periph_valid_o[sel]=1 is held every cycle until periph_ready_i[sel]=1.
  - On ready: capture periph_data_i[sel] (reads; writes capture 0), set err=0, go to RESP.
  - sel >= N_PERIPHS: no valid is asserted. Go to RESP next cycle with rdata=0, err=1.
  - Ready on non-selected peripherals is ignored.
- RESP:
  - mst_rvalid_o[winner]=1 for exactly one cycle, with mst_rdata_o and mst_err_o.
  - Then go to IDLE.
  - mst_rdata_o and mst_err_o hold their values until the next RESP.
- Timing:
  - Minimum access is 3 cycles: gnt, valid+ready, rvalid.
  - Back-to-back requests from different masters alternate strictly.
  - A master keeping req high after rvalid is re-arbitrated fairly in the next IDLE.
- Valid/ready contract:
  - periph_valid_o is at most one-hot.
  - Valid never drops before ready, except on timeout or reset.
- Reset mid-access:
  - Valid drops the cycle after rst_i is sampled.
  - No rvalid is issued; the pointer is restored to N_MASTERS-1.
- Request deassert: a master dropping req before gnt is simply not considered. After gnt the access completes regardless.

Optional Feature:
- Macro: UDMA_CFG_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on ACCESS entry and increments each ACCESS cycle.
  - When it reaches TIMEOUT_CYCLES without ready: drop valid, go to RESP with rdata=0, err=1.
  - Ready arriving in the same cycle as the timeout wins: normal completion, err=0.
- Undefined:
  - No counter is present; ACCESS waits indefinitely.
  - err is raised only for sel >= N_PERIPHS.

Test Plan:
- Reset, then master0 read sel=2 addr=5, periph 2 returns 0xCAFE0001 with ready 1 cycle after valid -> gnt0 at cycle 0, valid[2] cycles 1-2, rvalid0 at cycle 3 with rdata=0xCAFE0001, err=0.
- Masters 0 and 1 request continuously, writes to sel=1 with ready tied high -> grant order 0,1,0,1. periph_data_o matches each owner's wdata; no two valids overlap.
- Master1 write sel=9 with N_PERIPHS=8 -> no periph_valid_o bit ever set; rvalid1 with err=1, rdata=0.
- rst_i asserted while valid[3] held waiting for ready -> valid[3]=0 after that edge, no rvalid. The next request from master0 wins even if master1 also requests.
- With UDMA_CFG_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=4, ready never asserted -> valid high for 4 cycles, then rvalid with err=1.
- Same setup but ready asserted in the 4th cycle -> err=0, data captured.
